// File: rtl/inst_mem.sv
// Loadable instruction memory: streaming load port, registered one-cycle fetch port,
// halt-word guard beyond the loaded length and a sticky halted state.
module inst_mem #(
  parameter int unsigned     A         = 10,
  parameter int unsigned     W         = 9,
  parameter logic [W-1:0]    HALT_WORD = {W{1'b1}}
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           LoadStart,
  input  logic           LoadValid,
  input  logic           LoadLast,
  input  logic [W-1:0]   LoadData,
  output logic           LoadReady,
  output logic           LoadDone,
  output logic [A:0]     LoadCount,
  input  logic           FetchEn,
  input  logic [A-1:0]   InstAddress,
  output logic [W-1:0]   InstOut,
  output logic           InstValid,
  output logic           Halted
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  localparam logic [A-1:0] LAST_ADDR = {A{1'b1}};

  state_t       state;
  logic [A-1:0] ptr;
  logic [W-1:0] mem [2**A];
  logic [W-1:0] fetch_word;
  logic         load_accept;

  assign LoadReady   = (state == LOAD);
  assign load_accept = (state == LOAD) && LoadValid && !LoadStart;

  // Addresses at or beyond the loaded length read as halt, hiding stale contents.
  always_comb begin
    fetch_word = HALT_WORD;
    if ({1'b0, InstAddress} < LoadCount)
      fetch_word = mem[InstAddress];
  end

  // Storage carries no reset; LoadCount alone decides what is valid.
  always_ff @(posedge Clk) begin
    if (load_accept)
      mem[ptr] <= LoadData;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      ptr       <= '0;
      LoadCount <= '0;
      LoadDone  <= 1'b0;
      InstOut   <= '0;
      InstValid <= 1'b0;
      Halted    <= 1'b0;
    end else begin
      LoadDone  <= 1'b0;
      InstValid <= 1'b0;
      if (LoadStart) begin
        // Start or restart from any state; a word or fetch in this cycle is dropped.
        state     <= LOAD;
        ptr       <= '0;
        LoadCount <= '0;
        Halted    <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (LoadValid) begin
              LoadCount <= {1'b0, ptr} + {{A{1'b0}}, 1'b1};
              if (LoadLast || (ptr == LAST_ADDR)) begin
                state    <= RUN;
                LoadDone <= 1'b1;
              end
              if (ptr != LAST_ADDR)
                ptr <= ptr + 1'b1;
            end
          end
          RUN: begin
            if (FetchEn) begin
              InstOut   <= fetch_word;
              InstValid <= 1'b1;
              // Enter HALT on the same edge so Halted appears alongside the word.
              if (fetch_word == HALT_WORD) begin
                state  <= HALT;
                Halted <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_mem.sv
// Directed and randomized bench for inst_mem (A=3) against a simple array-based model.
module tb_inst_mem;

  localparam int A     = 3;
  localparam int W     = 9;
  localparam int DEPTH = 8;
  localparam logic [W-1:0] HALT = 9'h1FF;

  logic           Clk = 1'b0;
  logic           Reset = 1'b0;
  logic           LoadStart = 1'b0;
  logic           LoadValid = 1'b0;
  logic           LoadLast = 1'b0;
  logic [W-1:0]   LoadData = '0;
  logic           LoadReady;
  logic           LoadDone;
  logic [A:0]     LoadCount;
  logic           FetchEn = 1'b0;
  logic [A-1:0]   InstAddress = '0;
  logic [W-1:0]   InstOut;
  logic           InstValid;
  logic           Halted;

  inst_mem #(.A(A), .W(W), .HALT_WORD(HALT)) dut (
    .Clk(Clk), .Reset(Reset),
    .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadLast(LoadLast), .LoadData(LoadData),
    .LoadReady(LoadReady), .LoadDone(LoadDone), .LoadCount(LoadCount),
    .FetchEn(FetchEn), .InstAddress(InstAddress),
    .InstOut(InstOut), .InstValid(InstValid), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Reference model: program contents, loaded length, run/halt flags, last fetched word.
  logic [W-1:0] m_mem [DEPTH];
  int           m_count = 0;
  bit           m_run = 0;
  bit           m_halt = 0;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] prog [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    m_count = 0;
    m_run   = 0;
    m_halt  = 0;
    m_out   = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, LoadReady, 0);
    check({tag, "_done"},  LoadDone,  0);
    check({tag, "_count"}, LoadCount, 0);
    check({tag, "_out"},   InstOut,   0);
    check({tag, "_valid"}, InstValid, 0);
    check({tag, "_halted"}, Halted,   0);
  endtask

  // Streams n words from prog[] into an already-started load.
  task automatic load_body(input int n, input bit use_last);
    bit done_exp;
    for (int i = 0; i < n; i++) begin
      LoadValid = 1'b1;
      LoadData  = prog[i];
      LoadLast  = use_last && (i == n - 1);
      tick();
      m_mem[i] = prog[i];
      m_count  = i + 1;
      done_exp = (use_last && (i == n - 1)) || (i == DEPTH - 1);
      check("load_done", LoadDone, done_exp);
      check("load_count", LoadCount, m_count);
      check("load_ready", LoadReady, !done_exp);
      if (done_exp) m_run = 1;
    end
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
    tick();
    check("load_done_single", LoadDone, 0);
  endtask

  task automatic load_words(input int n, input bit use_last);
    LoadStart = 1'b1;
    tick();
    LoadStart = 1'b0;
    m_count = 0;
    m_run   = 0;
    m_halt  = 0;
    check("start_ready", LoadReady, 1);
    check("start_count", LoadCount, 0);
    check("start_halted", Halted, 0);
    load_body(n, use_last);
  endtask

  task automatic do_fetch(input int addr);
    logic [W-1:0] exp;
    bit vld;
    FetchEn     = 1'b1;
    InstAddress = addr[A-1:0];
    tick();
    FetchEn = 1'b0;
    vld = 0;
    if (m_run && !m_halt) begin
      exp    = (addr < m_count) ? m_mem[addr] : HALT;
      m_out  = exp;
      m_halt = (exp == HALT);
      vld    = 1;
    end
    check("fetch_valid", InstValid, vld);
    check("fetch_out", InstOut, m_out);
    check("fetch_halted", Halted, m_halt);
  endtask

  initial begin
    // Reset state, then fetches in IDLE are ignored.
    #1;
    check_reset_outputs("rst");
    tick();
    tick();
    Reset = 1'b1;
    tick();
    do_fetch(0);
    do_fetch(0);
    check("idle_count", LoadCount, 0);

    // Four-word program ending in the halt word.
    prog[0] = 9'h001; prog[1] = 9'h049; prog[2] = 9'h081; prog[3] = 9'h1FF;
    load_words(4, 1);
    for (int i = 0; i < 4; i++) do_fetch(i);
    check("prog4_halted", Halted, 1);
    do_fetch(0);

    // Guard beyond loaded length.
    prog[0] = 9'h012; prog[1] = 9'h034;
    load_words(2, 1);
    do_fetch(1);
    do_fetch(5);
    check("guard_out", InstOut, 9'h1FF);
    do_fetch(0);
    do_fetch(1);

    // Full load auto-completes; the extra word is refused.
    for (int i = 0; i < DEPTH; i++) prog[i] = 9'($urandom_range(0, 510));
    load_words(DEPTH, 0);
    LoadValid = 1'b1;
    LoadData  = 9'h0AA;
    #1;
    check("full_ready_low", LoadReady, 0);
    tick();
    LoadValid = 1'b0;
    check("full_count_hold", LoadCount, 8);
    check("full_no_done", LoadDone, 0);
    for (int i = 0; i < DEPTH; i++) do_fetch(i);
    do_fetch(7);
    do_fetch(3);

    // Restart mid-load with a colliding word.
    LoadStart = 1'b1;
    tick();
    LoadStart = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      LoadValid = 1'b1;
      LoadData  = 9'(9'h100 + i);
      tick();
      m_mem[i] = 9'(9'h100 + i);
      m_count  = i + 1;
      check("restart_part_count", LoadCount, m_count);
    end
    LoadStart = 1'b1;
    LoadValid = 1'b1;
    LoadData  = 9'h0AA;
    tick();
    LoadStart = 1'b0;
    LoadValid = 1'b0;
    m_count = 0;
    check("restart_count", LoadCount, 0);
    check("restart_ready", LoadReady, 1);
    check("restart_done", LoadDone, 0);
    prog[0] = 9'h021; prog[1] = 9'h042; prog[2] = 9'h063;
    load_body(3, 1);
    check("restart_final_count", LoadCount, 3);
    for (int i = 0; i < 4; i++) do_fetch(i);

    // Randomized programs and fetch streams.
    for (int r = 0; r < 6; r++) begin
      int n;
      bit ul;
      ul = ($urandom_range(0, 3) != 0);
      n  = ul ? int'($urandom_range(1, DEPTH)) : DEPTH;
      for (int i = 0; i < DEPTH; i++)
        prog[i] = ($urandom_range(0, 15) == 0) ? HALT : 9'($urandom_range(0, 510));
      load_words(n, ul);
      for (int k = 0; k < 12; k++) do_fetch(int'($urandom_range(0, DEPTH - 1)));
    end

    // Asynchronous reset in the middle of a load.
    LoadStart = 1'b1;
    tick();
    LoadStart = 1'b0;
    for (int i = 0; i < 2; i++) begin
      LoadValid = 1'b1;
      LoadData  = 9'(i + 5);
      tick();
    end
    #2 Reset = 1'b0;
    #1;
    check_reset_outputs("arst_load");
    model_reset();
    tick();
    #2 Reset = 1'b1;
    LoadValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_load_post_done", LoadDone, 0);
      check("arst_load_post_count", LoadCount, 0);
    end

    // Asynchronous reset during back-to-back fetches.
    for (int i = 0; i < 4; i++) prog[i] = 9'($urandom_range(0, 510));
    load_words(4, 1);
    do_fetch(0);
    do_fetch(1);
    do_fetch(2);
    FetchEn     = 1'b1;
    InstAddress = 3'd3;
    #2 Reset = 1'b0;
    #1;
    check_reset_outputs("arst_fetch");
    model_reset();
    tick();
    #2 Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_fetch_post_valid", InstValid, 0);
      check("arst_fetch_post_done", LoadDone, 0);
      check("arst_fetch_post_out", InstOut, 0);
    end
    FetchEn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
